// File: rtl/lm_sm_sequencer_if.sv
// Handshake and transfer bus of the load/store-multiple sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface lm_sm_sequencer_if;
  logic        start;
  logic        isLoad;
  logic [7:0]  regMask;
  logic [15:0] baseAddr;
  logic        hold;
  logic        stallPipe;
  logic        busy;
  logic [2:0]  regAddr;
  logic [15:0] memAddr;
  logic        regWrite;
  logic        r7Write;
  logic        memWrite;
  logic [1:0]  regSelect;
  logic        done;

  modport master (
    output start, isLoad, regMask, baseAddr, hold,
    input  stallPipe, busy, regAddr, memAddr, regWrite, r7Write, memWrite,
           regSelect, done
  );

  modport slave (
    input  start, isLoad, regMask, baseAddr, hold,
    output stallPipe, busy, regAddr, memAddr, regWrite, r7Write, memWrite,
           regSelect, done
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks the set bits of a register
// mask in ascending order, one transfer per cycle at consecutive addresses.
module lm_sm_sequencer (
  input logic              clk,
  input logic              reset,
  lm_sm_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] base_q, base_d;
  logic        load_q, load_d;

  logic [2:0]  low_idx;
  logic        found;
  logic [7:0]  mask_rest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && mask_q[i]) begin
        low_idx = 3'(i);
        found   = 1'b1;
      end
    end
  end

  // Clears the lowest set bit, i.e. the one being transferred this cycle.
  assign mask_rest = mask_q & (mask_q - 8'd1);

  assign bus.regSelect = 2'b00;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    load_d        = load_q;
    bus.stallPipe = 1'b0;
    bus.busy      = 1'b0;
    bus.regAddr   = '0;
    bus.memAddr   = '0;
    bus.regWrite  = 1'b0;
    bus.r7Write   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (|bus.regMask) begin
            mask_d        = bus.regMask;
            base_d        = bus.baseAddr;
            load_d        = bus.isLoad;
            cnt_d         = '0;
            state_d       = RUN;
            bus.stallPipe = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        bus.busy      = 1'b1;
        bus.stallPipe = 1'b1;
        bus.regAddr   = low_idx;
        bus.memAddr   = base_q + 16'(cnt_q);
        if (!bus.hold) begin
          if (load_q) begin
            bus.r7Write  = (low_idx == 3'd7);
            bus.regWrite = (low_idx != 3'd7);
          end else begin
            bus.memWrite = 1'b1;
          end
          mask_d = mask_rest;
          cnt_d  = cnt_q + 4'd1;
          if (mask_rest == 8'd0) state_d = DONE;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held quiet for the whole cycle in which reset is asserted.
    if (reset) begin
      bus.stallPipe = 1'b0;
      bus.busy      = 1'b0;
      bus.regAddr   = '0;
      bus.memAddr   = '0;
      bus.regWrite  = 1'b0;
      bus.r7Write   = 1'b0;
      bus.memWrite  = 1'b0;
      bus.done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: table of sequences plus hand-written hold,
// restart-ignore and reset-abort cases; strobes are matched against a queue.
module tb_lm_sm_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   start_cyc = 0;

  lm_sm_sequencer_if bus ();

  lm_sm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 regWrite, 1 r7Write, 2 memWrite, 3 done
  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  ra;
    logic [15:0] ma;
  } ev_t;

  typedef struct {
    logic        ld;
    logic [7:0]  mask;
    logic [15:0] base;
    int          lat;
  } vec_t;

  ev_t  q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_model(input logic ld, input logic [7:0] m, input logic [15:0] b);
    ev_t e;
    logic [15:0] a;
    a = b;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e.kind = ld ? ((i == 7) ? 2'd1 : 2'd0) : 2'd2;
        e.ra   = 3'(i);
        e.ma   = a;
        q.push_back(e);
        a = a + 16'd1;
      end
    end
    e.kind = 2'd3; e.ra = '0; e.ma = '0;
    q.push_back(e);
  endtask

  // Scoreboard side: every observed strobe or done pops one expected event.
  always @(negedge clk) begin
    logic [3:0] s;
    ev_t        e;
    logic [1:0] k;
    s = {bus.done, bus.memWrite, bus.r7Write, bus.regWrite};
    if (s != 4'd0) begin
      check("one_strobe", 32'($countones(s)), 32'd1);
      k = bus.done ? 2'd3 : bus.memWrite ? 2'd2 : bus.r7Write ? 2'd1 : 2'd0;
      if (q.size() == 0) begin
        check("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("ev_kind", {30'd0, k}, {30'd0, e.kind});
        if (e.kind != 2'd3) begin
          check("ev_regAddr", {29'd0, bus.regAddr}, {29'd0, e.ra});
          check("ev_memAddr", {16'd0, bus.memAddr}, {16'd0, e.ma});
          check("ev_regSelect", {30'd0, bus.regSelect}, 32'd0);
        end
      end
    end
  end

  task automatic start_seq(input logic ld, input logic [7:0] m, input logic [15:0] b);
    bus.start    = 1'b1;
    bus.isLoad   = ld;
    bus.regMask  = m;
    bus.baseAddr = b;
    start_cyc    = cyc;
    #1;
    check("stall_at_start", {31'd0, bus.stallPipe}, {31'd0, (m != 8'd0)});
    check("busy_at_start", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_done(input int exp_lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", 32'(cyc - start_cyc), 32'(exp_lat));
    check("busy_in_done", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("stall_after", {31'd0, bus.stallPipe}, 32'd0);
    check("done_after", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs"},
          {bus.busy, bus.stallPipe, bus.regWrite, bus.r7Write, bus.memWrite,
           bus.done, bus.regSelect, bus.regAddr, bus.memAddr},
          32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'b1000_0101, 16'h0100, 4};
    vecs[1] = '{1'b0, 8'hFF,        16'hFFFE, 9};
    vecs[2] = '{1'b1, 8'h00,        16'h1111, 1};
    vecs[3] = '{1'b1, 8'h80,        16'h7FFF, 2};
    vecs[4] = '{1'b0, 8'h01,        16'hFFFF, 2};
    vecs[5] = '{1'b1, 8'hFF,        16'h0010, 9};
    vecs[6] = '{1'b0, 8'h5A,        16'hABCD, 5};

    // Reset with a pending start: everything must stay quiet.
    reset = 1'b1;
    bus.start = 1'b1; bus.isLoad = 1'b1; bus.regMask = 8'h3C;
    bus.baseAddr = 16'h1234; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_quiet("idle");

    foreach (vecs[v]) begin
      push_model(vecs[v].ld, vecs[v].mask, vecs[v].base);
      start_seq(vecs[v].ld, vecs[v].mask, vecs[v].base);
      wait_done(vecs[v].lat);
    end

    // Hold for three cycles in the first RUN cycle.
    push_model(1'b1, 8'b0000_0110, 16'h0200);
    start_seq(1'b1, 8'b0000_0110, 16'h0200);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hold_strobes", {29'd0, bus.regWrite, bus.r7Write, bus.memWrite}, 32'd0);
      check("hold_regAddr", {29'd0, bus.regAddr}, 32'd1);
      check("hold_memAddr", {16'd0, bus.memAddr}, 32'h0200);
      check("hold_stall", {31'd0, bus.stallPipe}, 32'd1);
    end
    @(posedge clk); #1;
    bus.hold = 1'b0;
    wait_done(6);

    // start re-asserted mid-sequence with a different request.
    push_model(1'b0, 8'b0001_1010, 16'h1234);
    start_seq(1'b0, 8'b0001_1010, 16'h1234);
    @(posedge clk); #1;
    bus.isLoad = 1'b1; bus.regMask = 8'hF0; bus.baseAddr = 16'h9000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(4);

    // Reset in the second RUN cycle of an 8-register store aborts it.
    begin
      ev_t e;
      e.kind = 2'd2; e.ra = 3'd0; e.ma = 16'h4000;
      q.push_back(e);
    end
    start_seq(1'b0, 8'hFF, 16'h4000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_quiet("reset_in_run");
    @(posedge clk); #1;
    reset = 1'b0;
    check_quiet("after_abort");
    repeat (3) @(posedge clk);
    #1;
    check_quiet("stay_idle");
    push_model(1'b1, 8'b0100_0001, 16'h00F0);
    start_seq(1'b1, 8'b0100_0001, 16'h00F0);
    wait_done(3);

    repeat (2) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
